// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/handshake inputs and datapath control outputs of the multi-cycle control FSM
interface multicycle_control_if #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16
);
    logic [OPCODE_W-1:0] opcode;
    logic                mem_ready;
    logic                stall;

    logic                PCWrite;
    logic                PCWriteCond;
    logic                BranchNe;
    logic                IorD;
    logic                MemRead;
    logic                MemWrite;
    logic                IRWrite;
    logic                MemtoReg;
    logic                RegDst;
    logic                RegWrite;
    logic                ALUsrcA;
    logic [1:0]          PCSource;
    logic [1:0]          ALUsrcB;
    logic [ALUOP_W-1:0]  ALUop;
    logic [2:0]          state;
    logic                illegal;
    logic [CNT_W-1:0]    instr_count;

    modport master (
        output opcode, mem_ready, stall,
        input  PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUsrcA, PCSource, ALUsrcB, ALUop,
               state, illegal, instr_count
    );

    modport slave (
        input  opcode, mem_ready, stall,
        output PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUsrcA, PCSource, ALUsrcB, ALUop,
               state, illegal, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS main control FSM (FETCH/DECODE/EXEC/MEM/WB)
module multicycle_control #(
    parameter int OPCODE_W = 6,
    parameter int ALUOP_W  = 3,
    parameter int CNT_W    = 16
) (
    input logic               clk,
    input logic               reset,
    multicycle_control_if.slave bus
);
    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_R    = OPCODE_W'(6'b000000);
    localparam logic [OPCODE_W-1:0] OP_J    = OPCODE_W'(6'b000010);
    localparam logic [OPCODE_W-1:0] OP_BEQ  = OPCODE_W'(6'b000100);
    localparam logic [OPCODE_W-1:0] OP_BNE  = OPCODE_W'(6'b000101);
    localparam logic [OPCODE_W-1:0] OP_ADDI = OPCODE_W'(6'b001000);
    localparam logic [OPCODE_W-1:0] OP_LW   = OPCODE_W'(6'b100011);
    localparam logic [OPCODE_W-1:0] OP_SW   = OPCODE_W'(6'b101011);

    localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
    localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
    localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);

    state_t              state_q, state_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                retire;
    logic                legal;

    always_comb begin
        legal = (bus.opcode == OP_R)   || (bus.opcode == OP_J)    ||
                (bus.opcode == OP_BEQ) || (bus.opcode == OP_BNE)  ||
                (bus.opcode == OP_ADDI)|| (bus.opcode == OP_LW)   ||
                (bus.opcode == OP_SW);
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        retire  = 1'b0;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d    = bus.opcode;
                state_d = legal ? S_EXEC : S_FETCH;
            end
            S_EXEC: begin
                if (op_q == OP_LW || op_q == OP_SW)       state_d = S_MEM;
                else if (op_q == OP_ADDI || op_q == OP_R) state_d = S_WB;
                else begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end
            end
            S_MEM: begin
                if (bus.mem_ready) begin
                    state_d = (op_q == OP_LW) ? S_WB : S_FETCH;
                    retire  = (op_q != OP_LW);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase
        // stall freezes all architectural state, taking priority over mem_ready
        if (bus.stall) begin
            state_d = state_q;
            op_d    = op_q;
            retire  = 1'b0;
        end
        cnt_d = cnt_q + CNT_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.BranchNe    = 1'b0;
        bus.IorD        = 1'b0;
        bus.MemRead     = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.MemtoReg    = 1'b0;
        bus.RegDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUsrcA     = 1'b0;
        bus.PCSource    = 2'b00;
        bus.ALUsrcB     = 2'b00;
        bus.ALUop       = ALU_ADD;
        bus.illegal     = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    bus.MemRead = 1'b1;
                    bus.ALUsrcB = 2'b01;
                    bus.IRWrite = bus.mem_ready;
                    bus.PCWrite = bus.mem_ready;
                end
                S_DECODE: begin
                    bus.ALUsrcB = 2'b11;
                    bus.illegal = !legal;
                end
                S_EXEC: begin
                    if (op_q == OP_J) begin
                        bus.PCWrite  = 1'b1;
                        bus.PCSource = 2'b10;
                    end else if (op_q == OP_BEQ || op_q == OP_BNE) begin
                        bus.ALUsrcA     = 1'b1;
                        bus.ALUop       = ALU_SUB;
                        bus.PCWriteCond = 1'b1;
                        bus.PCSource    = 2'b01;
                        bus.BranchNe    = (op_q == OP_BNE);
                    end else if (op_q == OP_R) begin
                        bus.ALUsrcA = 1'b1;
                        bus.ALUop   = ALU_FUNCT;
                    end else begin
                        bus.ALUsrcA = 1'b1;
                        bus.ALUsrcB = 2'b10;
                    end
                end
                S_MEM: begin
                    // MemWrite is held across wait cycles; memory treats it as one access
                    bus.IorD     = 1'b1;
                    bus.MemRead  = (op_q == OP_LW);
                    bus.MemWrite = (op_q == OP_SW);
                end
                S_WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemtoReg = (op_q == OP_LW);
                    bus.RegDst   = (op_q == OP_R);
                end
                default: ;
            endcase
            if (bus.stall) begin
                bus.PCWrite     = 1'b0;
                bus.PCWriteCond = 1'b0;
                bus.IRWrite     = 1'b0;
                bus.MemWrite    = 1'b0;
                bus.RegWrite    = 1'b0;
                bus.illegal     = 1'b0;
            end
        end
    end

    assign bus.state       = reset ? 3'd0 : 3'(state_q);
    assign bus.instr_count = reset ? '0 : cnt_q;
endmodule
